mul_pipe: RTL and testbench

Pipelined RV32M multiply unit between the multiply reservation station and the physical register file / ROB writeback. Accepts one issued MUL/MULH/MULHSU/MULHU per cycle with operand values already read, carries destination tags down a fixed-depth pipeline, and presents one result per cycle on a valid/ready writeback port. The writeback port drives the register file's multiply write port (`regf_we_mul`, `rd_mul`, `rd_v_mul`, `arch_rd_mul`) and the ROB completion. Supports whole-pipe stall on writeback backpressure and a single-cycle flush.

---
 rtl/mul_pipe_if.sv | 41 ++++
 rtl/mul_pipe.sv | 85 ++++++++
 tb/tb_mul_pipe.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pipe_if.sv
// mul_pipe issue/writeback bundle: issue channel, writeback channel, flush.
// slave = multiply unit side, master = reservation station / writeback side.
interface mul_pipe_if #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ARCH_REG_BITS = 5,
  parameter int ROB_IDX_BITS  = 5
);
  logic                     flush;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [2:0]               issue_funct3;
  logic [31:0]              issue_rs1_v;
  logic [31:0]              issue_rs2_v;
  logic [PHYS_REG_BITS-1:0] issue_rd_phys;
  logic [ARCH_REG_BITS-1:0] issue_rd_arch;
  logic [ROB_IDX_BITS-1:0]  issue_rob_idx;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [PHYS_REG_BITS-1:0] wb_rd_phys;
  logic [ARCH_REG_BITS-1:0] wb_rd_arch;
  logic [ROB_IDX_BITS-1:0]  wb_rob_idx;
  logic [31:0]              wb_value;

  modport slave (
    input  flush, issue_valid, issue_funct3,
    input  issue_rs1_v, issue_rs2_v,
    input  issue_rd_phys, issue_rd_arch, issue_rob_idx,
    input  wb_ready,
    output issue_ready, wb_valid,
    output wb_rd_phys, wb_rd_arch, wb_rob_idx, wb_value
  );

  modport master (
    output flush, issue_valid, issue_funct3,
    output issue_rs1_v, issue_rs2_v,
    output issue_rd_phys, issue_rd_arch, issue_rob_idx,
    output wb_ready,
    input  issue_ready, wb_valid,
    input  wb_rd_phys, wb_rd_arch, wb_rob_idx, wb_value
  );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined RV32M MUL/MULH/MULHSU/MULHU unit, NUM_STAGES deep.
// Ports: clk, rst (async, active high), io (mul_pipe_if.slave).
module mul_pipe #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ARCH_REG_BITS = 5,
  parameter int ROB_IDX_BITS  = 5,
  parameter int NUM_STAGES    = 4
) (
  input  logic      clk,
  input  logic      rst,
  mul_pipe_if.slave io
);
  localparam int L = NUM_STAGES - 1;

  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] rd_phys;
    logic [ARCH_REG_BITS-1:0] rd_arch;
    logic [ROB_IDX_BITS-1:0]  rob_idx;
    logic [31:0]              value;
  } slot_t;

  logic [NUM_STAGES-1:0] v_q, v_d;
  slot_t slot_q [NUM_STAGES];
  slot_t slot_d [NUM_STAGES];

  logic               advance;
  logic               fire;
  logic               rs1_sx;
  logic               rs2_sx;
  logic signed [32:0] a_s;
  logic signed [32:0] b_s;
  logic signed [63:0] prod;
  logic [31:0]        res;

  always_comb begin
    advance = !v_q[L] || io.wb_ready;
    fire    = io.issue_valid && advance && !io.flush;

    // rs1 signed for MULH (01) and MULHSU (10); rs2 only for MULH.
    rs1_sx = io.issue_funct3[1] ^ io.issue_funct3[0];
    rs2_sx = (io.issue_funct3[1:0] == 2'b01);
    a_s = {rs1_sx & io.issue_rs1_v[31], io.issue_rs1_v};
    b_s = {rs2_sx & io.issue_rs2_v[31], io.issue_rs2_v};

    // Low 64 bits of the 33x33 product are all any variant needs.
    prod = 64'(a_s) * 64'(b_s);
    if (io.issue_funct3[1:0] == 2'b00) res = prod[31:0];
    else                               res = prod[63:32];
    // x0 destination still completes in the ROB, but writes zero.
    if (io.issue_rd_arch == '0) res = '0;

    v_d    = v_q;
    slot_d = slot_q;
    if (advance) begin
      v_d = {v_q[L-1:0], fire};
      slot_d[0] = '{rd_phys: io.issue_rd_phys,
                    rd_arch: io.issue_rd_arch,
                    rob_idx: io.issue_rob_idx,
                    value:   res};
      for (int i = 1; i < NUM_STAGES; i++) begin
        slot_d[i] = slot_q[i-1];
      end
    end
    if (io.flush) v_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      slot_q <= slot_d;
    end
  end

  assign io.issue_ready = advance;
  assign io.wb_valid    = v_q[L];
  assign io.wb_rd_phys  = slot_q[L].rd_phys;
  assign io.wb_rd_arch  = slot_q[L].rd_arch;
  assign io.wb_rob_idx  = slot_q[L].rob_idx;
  assign io.wb_value    = slot_q[L].value;
endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_mul_pipe;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_pipe_if #(.PHYS_REG_BITS(6), .ARCH_REG_BITS(5),
                .ROB_IDX_BITS(5)) io ();

  mul_pipe #(.PHYS_REG_BITS(6), .ARCH_REG_BITS(5),
             .ROB_IDX_BITS(5), .NUM_STAGES(NS)) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t funct3=%0d)",
               nm, act, exp, $time, io.issue_funct3);
    end
  endtask

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_val(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b,
      input logic [4:0] arch);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f[1:0])
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    if (arch == 5'd0) return 32'd0;
    return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  typedef struct {
    logic [31:0] val;
    logic [5:0]  phys;
    logic [4:0]  arch;
    logic [4:0]  rob;
    int          age;
  } op_t;

  op_t q[$];
  op_t nop;
  bit  m_front;
  bit  m_adv;

  // Each op ages by one per advancing edge; it is presented once it
  // has aged NS-1 times.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      m_front = (q.size() > 0) && (q[0].age == NS - 1);
      m_adv   = !m_front || io.wb_ready;
      if (io.flush) begin
        q.delete();
      end else if (m_adv) begin
        if (m_front) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (io.issue_valid) begin
          nop.val  = ref_val(io.issue_funct3, io.issue_rs1_v,
                             io.issue_rs2_v, io.issue_rd_arch);
          nop.phys = io.issue_rd_phys;
          nop.arch = io.issue_rd_arch;
          nop.rob  = io.issue_rob_idx;
          nop.age  = 0;
          q.push_back(nop);
        end
      end
    end
  end

  bit c_exp_v;
  always @(negedge clk) begin
    c_exp_v = (q.size() > 0) && (q[0].age == NS - 1);
    chk("m_wb_valid", 64'(io.wb_valid), 64'(c_exp_v));
    chk("m_issue_ready", 64'(io.issue_ready),
        64'(!c_exp_v || io.wb_ready));
    if (c_exp_v) begin
      chk("m_wb_value", 64'(io.wb_value), 64'(q[0].val));
      chk("m_wb_rd_phys", 64'(io.wb_rd_phys), 64'(q[0].phys));
      chk("m_wb_rd_arch", 64'(io.wb_rd_arch), 64'(q[0].arch));
      chk("m_wb_rob_idx", 64'(io.wb_rob_idx), 64'(q[0].rob));
    end
    if (rst) begin
      chk("rst_wb_value", 64'(io.wb_value), 64'd0);
      chk("rst_wb_rd_phys", 64'(io.wb_rd_phys), 64'd0);
      chk("rst_wb_rob_idx", 64'(io.wb_rob_idx), 64'd0);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
      input logic [31:0] b, input logic [5:0] p,
      input logic [4:0] ar, input logic [4:0] rb);
    io.issue_valid   = 1'b1;
    io.issue_funct3  = f;
    io.issue_rs1_v   = a;
    io.issue_rs2_v   = b;
    io.issue_rd_phys = p;
    io.issue_rd_arch = ar;
    io.issue_rob_idx = rb;
    #1 chk("issue_ready_at_issue", 64'(io.issue_ready), 64'd1);
    @(posedge clk);
    #1 io.issue_valid = 1'b0;
  endtask

  logic [31:0] got[$];
  int          got_cyc[$];

  task automatic collect(input int n);
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (io.wb_valid && io.wb_ready) begin
        got.push_back(io.wb_value);
        got_cyc.push_back(i);
      end
    end
  endtask

  // Cycles from the fire edge until wb_valid, counting the fire edge.
  task automatic wait_wb(output int cnt);
    cnt = 1;
    while (!io.wb_valid && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask

  int cnt;
  logic [31:0] exp6 [6];
  logic [31:0] exp4 [4];

  initial begin
    io.flush = 1'b0;
    io.issue_valid = 1'b0;
    io.issue_funct3 = 3'd0;
    io.issue_rs1_v = '0;
    io.issue_rs2_v = '0;
    io.issue_rd_phys = '0;
    io.issue_rd_arch = '0;
    io.issue_rob_idx = '0;
    io.wb_ready = 1'b1;

    #2;
    chk("reset_wb_valid", 64'(io.wb_valid), 64'd0);
    chk("reset_wb_value", 64'(io.wb_value), 64'd0);
    chk("reset_wb_rd_arch", 64'(io.wb_rd_arch), 64'd0);
    chk("reset_issue_ready", 64'(io.issue_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // MUL 7 x -3
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 6'd12, 5'd1, 5'd3);
    wait_wb(cnt);
    chk("mul_latency", 64'(cnt), 64'(NS));
    chk("mul_value", 64'(io.wb_value), 64'hFFFF_FFEB);
    chk("mul_rd_phys", 64'(io.wb_rd_phys), 64'd12);
    chk("mul_rob_idx", 64'(io.wb_rob_idx), 64'd3);
    repeat (3) @(posedge clk);
    #1;

    // Six back-to-back ops, results in issue order.
    exp6 = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF,
             32'h8000_0000, 32'h0, 32'hFFFF_FFFE};
    fork
      begin
        issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd1, 5'd1, 5'd1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd2, 5'd2, 5'd2);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd3, 5'd3, 5'd3);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd4, 5'd4, 5'd4);
        issue(3'd0, 32'd5, 32'd5, 6'd5, 5'd0, 5'd5);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 5'd6, 5'd6);
      end
      collect(16);
    join
    chk("b2b_count", 64'(got.size()), 64'd6);
    if (got.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("b2b_value", 64'(got[i]), 64'(exp6[i]));
      chk("b2b_consecutive", 64'(got_cyc[5] - got_cyc[0]), 64'd5);
    end
    #1;

    // Stall: fill with wb_ready low, hold 5 cycles, then drain.
    io.wb_ready = 1'b0;
    issue(3'd0, 32'd2, 32'd3, 6'd21, 5'd1, 5'd11);
    issue(3'd0, 32'd4, 32'd5, 6'd22, 5'd2, 5'd12);
    issue(3'd0, 32'd6, 32'd7, 6'd23, 5'd3, 5'd13);
    issue(3'd0, 32'd8, 32'd9, 6'd24, 5'd4, 5'd14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_issue_ready", 64'(io.issue_ready), 64'd0);
      chk("stall_wb_valid", 64'(io.wb_valid), 64'd1);
      chk("stall_wb_value", 64'(io.wb_value), 64'd6);
      chk("stall_wb_rd_phys", 64'(io.wb_rd_phys), 64'd21);
    end
    @(posedge clk);
    #1 io.wb_ready = 1'b1;
    exp4 = '{32'd6, 32'd20, 32'd42, 32'd72};
    collect(10);
    chk("drain_count", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("drain_value", 64'(got[i]), 64'(exp4[i]));
    end
    #1;

    // Flush with 3 in flight and an issue in the flush cycle.
    issue(3'd0, 32'd3, 32'd3, 6'd31, 5'd1, 5'd1);
    issue(3'd0, 32'd4, 32'd4, 6'd32, 5'd1, 5'd2);
    issue(3'd0, 32'd5, 32'd6, 6'd33, 5'd1, 5'd3);
    io.issue_valid = 1'b1;
    io.issue_funct3 = 3'd0;
    io.issue_rs1_v = 32'd9;
    io.issue_rs2_v = 32'd9;
    io.flush = 1'b1;
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    io.issue_valid = 1'b0;
    chk("post_flush_wb_valid", 64'(io.wb_valid), 64'd0);
    issue(3'd0, 32'd11, 32'd11, 6'd20, 5'd3, 5'd9);
    wait_wb(cnt);
    chk("post_flush_latency", 64'(cnt), 64'(NS));
    chk("post_flush_value", 64'(io.wb_value), 64'd121);
    chk("post_flush_rd_phys", 64'(io.wb_rd_phys), 64'd20);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while a result is presented.
    issue(3'd0, 32'd10, 32'd10, 6'd40, 5'd1, 5'd20);
    issue(3'd0, 32'd12, 32'd12, 6'd41, 5'd1, 5'd21);
    io.wb_ready = 1'b0;
    wait_wb(cnt);
    chk("pre_reset_wb_valid", 64'(io.wb_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_wb_valid", 64'(io.wb_valid), 64'd0);
    chk("async_reset_wb_value", 64'(io.wb_value), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    io.wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after_reset_wb_valid", 64'(io.wb_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
